// File: rtl/control_posicion_rana_pkg.sv
// control_posicion_rana_pkg
//   Shared definitions for the frog position stage: FSM state encoding,
//   board limits, goal row/columns and default spawn cell.
//   No ports. Imported by control_posicion_rana_if, detector_flanco and
//   control_posicion_rana.
package control_posicion_rana_pkg;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        ACTIVA = 2'd1,
        LLEGO  = 2'd2,
        MUERTA = 2'd3
    } estado_t;

    localparam int unsigned POS_W = 3;

    localparam logic [POS_W-1:0] POS_MIN = 3'd0;
    localparam logic [POS_W-1:0] POS_MAX = 3'd7;

    localparam logic [POS_W-1:0] FILA_META  = 3'd7;
    localparam logic [POS_W-1:0] COL_META_A = 3'd1;
    localparam logic [POS_W-1:0] COL_META_B = 3'd4;
    localparam logic [POS_W-1:0] COL_META_C = 3'd6;

    localparam logic [POS_W-1:0] POS_INI_X_DEF = 3'd3;
    localparam logic [POS_W-1:0] POS_INI_Y_DEF = 3'd0;

    function automatic logic es_columna_meta(input logic [POS_W-1:0] x);
        return (x == COL_META_A) || (x == COL_META_B) || (x == COL_META_C);
    endfunction

endpackage

// File: rtl/control_posicion_rana_if.sv
// control_posicion_rana_if
//   Bundles the frog position stage's control inputs and position/event
//   outputs.
//   master: drives CR_RANA_INI, CR_BTN_*, CR_CHOQUE; reads CR_POSX/Y,
//           CR_PERDIO, CR_MOVIO.
//   slave : the position stage itself (opposite directions).
interface control_posicion_rana_if
    import control_posicion_rana_pkg::*;
#(
    parameter int unsigned DATAWIDTH_POS = POS_W
);
    logic                     CR_RANA_INI;
    logic                     CR_BTN_UP;
    logic                     CR_BTN_DOWN;
    logic                     CR_BTN_LEFT;
    logic                     CR_BTN_RIGHT;
    logic                     CR_CHOQUE;
    logic [DATAWIDTH_POS-1:0] CR_POSX;
    logic [DATAWIDTH_POS-1:0] CR_POSY;
    logic                     CR_PERDIO;
    logic                     CR_MOVIO;

    modport master (
        output CR_RANA_INI, CR_BTN_UP, CR_BTN_DOWN, CR_BTN_LEFT, CR_BTN_RIGHT,
               CR_CHOQUE,
        input  CR_POSX, CR_POSY, CR_PERDIO, CR_MOVIO
    );

    modport slave (
        input  CR_RANA_INI, CR_BTN_UP, CR_BTN_DOWN, CR_BTN_LEFT, CR_BTN_RIGHT,
               CR_CHOQUE,
        output CR_POSX, CR_POSY, CR_PERDIO, CR_MOVIO
    );
endinterface

// File: rtl/control_posicion_rana_detector_flanco.sv
// detector_flanco
//   Two-flop synchronizer for an asynchronous push-button followed by a
//   rising-edge detector. A button sampled high at edge k yields pulso_o
//   during the cycle that ends at edge k+2; a held button pulses once.
//   Ports: CR_CLOCK_50 (clock), CR_RESET (async, active-high),
//          btn_i (raw button), pulso_o (one-cycle request).
module detector_flanco
    import control_posicion_rana_pkg::*;
(
    input  logic CR_CLOCK_50,
    input  logic CR_RESET,
    input  logic btn_i,
    output logic pulso_o
);
    // [0],[1]: synchronizer stages; [2]: previous synchronized sample
    logic [2:0] sinc_q;

    always_ff @(posedge CR_CLOCK_50 or posedge CR_RESET) begin
        if (CR_RESET) begin
            sinc_q <= '0;
        end else begin
            sinc_q <= {sinc_q[1:0], btn_i};
        end
    end

    assign pulso_o = sinc_q[1] & ~sinc_q[2];
endmodule

// File: rtl/control_posicion_rana.sv
// control_posicion_rana
//   Frog position stage on the 8x8 board. Converts button requests into
//   rate-limited, clamped moves, gates entry into the goal row, and reports
//   death from collision or (optionally) per-frog timeout.
//   Ports: CR_CLOCK_50 (clock), CR_RESET (async, active-high),
//          bus (control_posicion_rana_if.slave: CR_RANA_INI, CR_BTN_*,
//          CR_CHOQUE in; CR_POSX, CR_POSY, CR_PERDIO, CR_MOVIO out).
//   Build option: CONTROL_POSICION_TIMEOUT_EN enables the per-frog timer.
module control_posicion_rana
    import control_posicion_rana_pkg::*;
#(
    parameter int unsigned              DATAWIDTH_POS = POS_W,
    parameter logic [DATAWIDTH_POS-1:0] POS_INI_X     = DATAWIDTH_POS'(POS_INI_X_DEF),
    parameter logic [DATAWIDTH_POS-1:0] POS_INI_Y     = DATAWIDTH_POS'(POS_INI_Y_DEF),
    parameter int unsigned              MOVE_HOLD     = 5_000_000,
    parameter int unsigned              TIEMPO_MAX    = 1_500_000_000
)(
    input  logic                   CR_CLOCK_50,
    input  logic                   CR_RESET,
    control_posicion_rana_if.slave bus
);
    localparam int unsigned LOCK_W = $clog2(MOVE_HOLD);
    localparam logic [DATAWIDTH_POS-1:0] LIM_MIN = DATAWIDTH_POS'(POS_MIN);
    localparam logic [DATAWIDTH_POS-1:0] LIM_MAX = DATAWIDTH_POS'(POS_MAX);
    localparam logic [DATAWIDTH_POS-1:0] META    = DATAWIDTH_POS'(FILA_META);

    if (MOVE_HOLD < 2 || TIEMPO_MAX < 2) begin : g_param_chk
        $error("control_posicion_rana: MOVE_HOLD and TIEMPO_MAX must be >= 2");
    end

    estado_t                  state_q, state_d;
    logic [DATAWIDTH_POS-1:0] posx_q, posx_d, posy_q, posy_d;
    logic [LOCK_W-1:0]        lock_q, lock_d;
    logic                     perdio_q, perdio_d, movio_q, movio_d;
    logic                     req_up, req_down, req_left, req_right;
    logic                     mov_valido, timeout;
    logic [DATAWIDTH_POS-1:0] posx_mov, posy_mov, posy_inc;

    detector_flanco u_flanco_up    (.CR_CLOCK_50(CR_CLOCK_50), .CR_RESET(CR_RESET), .btn_i(bus.CR_BTN_UP),    .pulso_o(req_up));
    detector_flanco u_flanco_down  (.CR_CLOCK_50(CR_CLOCK_50), .CR_RESET(CR_RESET), .btn_i(bus.CR_BTN_DOWN),  .pulso_o(req_down));
    detector_flanco u_flanco_left  (.CR_CLOCK_50(CR_CLOCK_50), .CR_RESET(CR_RESET), .btn_i(bus.CR_BTN_LEFT),  .pulso_o(req_left));
    detector_flanco u_flanco_right (.CR_CLOCK_50(CR_CLOCK_50), .CR_RESET(CR_RESET), .btn_i(bus.CR_BTN_RIGHT), .pulso_o(req_right));

`ifdef CONTROL_POSICION_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIEMPO_MAX);
    logic [TIMER_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (bus.CR_RANA_INI || state_q == ESPERA) begin
            timer_d = '0;
        end else if (state_q == ACTIVA && timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge CR_CLOCK_50 or posedge CR_RESET) begin
        if (CR_RESET) timer_q <= '0;
        else          timer_q <= timer_d;
    end

    assign timeout = (state_q == ACTIVA) && (timer_q == TIMER_W'(TIEMPO_MAX - 1));
`else
    assign timeout = 1'b0;
`endif

    assign posy_inc = posy_q + 1'b1;

    // Strict priority: a blocked higher-priority request still masks
    // the lower ones in the same cycle.
    always_comb begin
        mov_valido = 1'b0;
        posx_mov   = posx_q;
        posy_mov   = posy_q;
        if (req_up) begin
            if (posy_q != LIM_MAX &&
                (posy_inc != META || es_columna_meta(POS_W'(posx_q)))) begin
                mov_valido = 1'b1;
                posy_mov   = posy_inc;
            end
        end else if (req_down) begin
            if (posy_q != LIM_MIN) begin
                mov_valido = 1'b1;
                posy_mov   = posy_q - 1'b1;
            end
        end else if (req_left) begin
            if (posx_q != LIM_MIN) begin
                mov_valido = 1'b1;
                posx_mov   = posx_q - 1'b1;
            end
        end else if (req_right) begin
            if (posx_q != LIM_MAX) begin
                mov_valido = 1'b1;
                posx_mov   = posx_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        posx_d   = posx_q;
        posy_d   = posy_q;
        perdio_d = 1'b0;
        movio_d  = 1'b0;
        lock_d   = (lock_q != '0) ? lock_q - 1'b1 : lock_q;
        if (bus.CR_RANA_INI) begin
            state_d = ESPERA;
            posx_d  = POS_INI_X;
            posy_d  = POS_INI_Y;
            lock_d  = '0;
        end else begin
            case (state_q)
                ESPERA: begin
                    posx_d  = POS_INI_X;
                    posy_d  = POS_INI_Y;
                    state_d = ACTIVA;
                end
                ACTIVA: begin
                    if (bus.CR_CHOQUE || timeout) begin
                        perdio_d = 1'b1;
                        state_d  = MUERTA;
                    end else if (lock_q == '0 && mov_valido) begin
                        posx_d  = posx_mov;
                        posy_d  = posy_mov;
                        movio_d = 1'b1;
                        lock_d  = LOCK_W'(MOVE_HOLD - 1);
                        if (posy_mov == META) state_d = LLEGO;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CR_CLOCK_50 or posedge CR_RESET) begin
        if (CR_RESET) begin
            state_q  <= ESPERA;
            posx_q   <= POS_INI_X;
            posy_q   <= POS_INI_Y;
            lock_q   <= '0;
            perdio_q <= 1'b0;
            movio_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            lock_q   <= lock_d;
            perdio_q <= perdio_d;
            movio_q  <= movio_d;
        end
    end

    assign bus.CR_POSX   = posx_q;
    assign bus.CR_POSY   = posy_q;
    assign bus.CR_PERDIO = perdio_q;
    assign bus.CR_MOVIO  = movio_q;
endmodule

// File: tb/tb_control_posicion_rana.sv
// tb_control_posicion_rana
//   Directed bench for control_posicion_rana with MOVE_HOLD=4, TIEMPO_MAX=50.
//   Timeout expectations follow CONTROL_POSICION_TIMEOUT_EN.
module tb_control_posicion_rana;
    logic        CR_CLOCK_50 = 1'b0;
    logic        CR_RESET;
    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

`ifdef CONTROL_POSICION_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    control_posicion_rana_if #(.DATAWIDTH_POS(3)) bus ();

    control_posicion_rana #(
        .DATAWIDTH_POS(3),
        .POS_INI_X    (3'd3),
        .POS_INI_Y    (3'd0),
        .MOVE_HOLD    (4),
        .TIEMPO_MAX   (50)
    ) dut (
        .CR_CLOCK_50(CR_CLOCK_50),
        .CR_RESET   (CR_RESET),
        .bus        (bus)
    );

    always #5 CR_CLOCK_50 = ~CR_CLOCK_50;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge CR_CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Button high for one sampling edge; returns #1 after the edge at which
    // the resulting request is acted on.
    task automatic pulsar(input logic [3:0] m);
        bus.CR_BTN_UP    = m[3];
        bus.CR_BTN_DOWN  = m[2];
        bus.CR_BTN_LEFT  = m[1];
        bus.CR_BTN_RIGHT = m[0];
        tick(1);
        bus.CR_BTN_UP    = 1'b0;
        bus.CR_BTN_DOWN  = 1'b0;
        bus.CR_BTN_LEFT  = 1'b0;
        bus.CR_BTN_RIGHT = 1'b0;
        tick(2);
    endtask

    task automatic rearm();
        bus.CR_RANA_INI = 1'b1;
        tick(1);
        bus.CR_RANA_INI = 1'b0;
        tick(1);
    endtask

    initial begin
        CR_RESET         = 1'b1;
        bus.CR_RANA_INI  = 1'b1;
        bus.CR_BTN_UP    = 1'b0;
        bus.CR_BTN_DOWN  = 1'b0;
        bus.CR_BTN_LEFT  = 1'b0;
        bus.CR_BTN_RIGHT = 1'b0;
        bus.CR_CHOQUE    = 1'b0;
        tick(3);
        chk("reset_posx", bus.CR_POSX, 3);
        chk("reset_posy", bus.CR_POSY, 0);
        chk("reset_perdio", bus.CR_PERDIO, 0);
        chk("reset_movio", bus.CR_MOVIO, 0);
        CR_RESET = 1'b0;
        tick(1);
        pulsar(B_UP);
        chk("espera_no_move", bus.CR_POSY, 0);

        // First move latency, held button, lockout drop, re-acceptance
        rearm();
        bus.CR_BTN_UP = 1'b1;
        tick(1);
        bus.CR_BTN_UP = 1'b0;
        tick(1);
        chk("lat_k1_posy", bus.CR_POSY, 0);
        chk("lat_k1_movio", bus.CR_MOVIO, 0);
        tick(1);
        chk("lat_k2_posy", bus.CR_POSY, 1);
        chk("lat_k2_movio", bus.CR_MOVIO, 1);
        chk("lat_k2_posx", bus.CR_POSX, 3);
        tick(1);
        chk("movio_one_cycle", bus.CR_MOVIO, 0);
        tick(3);
        bus.CR_BTN_UP = 1'b1;
        tick(20);
        bus.CR_BTN_UP = 1'b0;
        tick(3);
        chk("held_single_step", bus.CR_POSY, 2);
        pulsar(B_UP);
        chk("accept_y3", bus.CR_POSY, 3);
        chk("accept_y3_movio", bus.CR_MOVIO, 1);
        pulsar(B_UP);
        chk("lockout_drop_posy", bus.CR_POSY, 3);
        chk("lockout_drop_movio", bus.CR_MOVIO, 0);
        tick(4);
        pulsar(B_UP);
        chk("after_lockout_posy", bus.CR_POSY, 4);

        // Goal gating
        rearm();
        chk("rearm_posy", bus.CR_POSY, 0);
        for (int i = 1; i <= 6; i++) begin
            pulsar(B_UP);
            chk("climb_posy", bus.CR_POSY, 32'(i));
            tick(2);
        end
        pulsar(B_UP);
        chk("goal_col3_blocked", bus.CR_POSY, 6);
        chk("goal_col3_no_movio", bus.CR_MOVIO, 0);
        pulsar(B_RIGHT);
        chk("ignored_no_lock_posx", bus.CR_POSX, 4);
        chk("ignored_no_lock_movio", bus.CR_MOVIO, 1);
        tick(2);
        pulsar(B_UP);
        chk("goal_reached_posy", bus.CR_POSY, 7);
        chk("goal_reached_movio", bus.CR_MOVIO, 1);
        bus.CR_CHOQUE = 1'b1;
        tick(1);
        chk("llego_choque_perdio_a", bus.CR_PERDIO, 0);
        tick(1);
        chk("llego_choque_perdio_b", bus.CR_PERDIO, 0);
        bus.CR_CHOQUE = 1'b0;
        tick(4);
        pulsar(B_DOWN);
        chk("llego_frozen_posy", bus.CR_POSY, 7);
        tick(60);
        chk("llego_no_timeout", bus.CR_PERDIO, 0);

        // Clamping and simultaneous requests
        rearm();
        pulsar(B_DOWN);
        chk("clamp_y0_posy", bus.CR_POSY, 0);
        chk("clamp_y0_movio", bus.CR_MOVIO, 0);
        pulsar(B_LEFT);
        chk("left_x2", bus.CR_POSX, 2);
        tick(2);
        pulsar(B_LEFT);
        chk("left_x1", bus.CR_POSX, 1);
        tick(2);
        pulsar(B_LEFT);
        chk("left_x0", bus.CR_POSX, 0);
        tick(2);
        pulsar(B_LEFT);
        chk("clamp_x0_posx", bus.CR_POSX, 0);
        chk("clamp_x0_movio", bus.CR_MOVIO, 0);
        pulsar(B_UP | B_LEFT);
        chk("prio_up_posy", bus.CR_POSY, 1);
        chk("prio_up_posx", bus.CR_POSX, 0);

        // Collision beats a same-cycle move; re-spawn
        rearm();
        pulsar(B_RIGHT);
        chk("pre_choque_posx", bus.CR_POSX, 4);
        tick(2);
        bus.CR_BTN_UP = 1'b1;
        tick(1);
        bus.CR_BTN_UP = 1'b0;
        tick(1);
        bus.CR_CHOQUE = 1'b1;
        tick(1);
        chk("choque_perdio", bus.CR_PERDIO, 1);
        chk("choque_posy_held", bus.CR_POSY, 0);
        chk("choque_posx_held", bus.CR_POSX, 4);
        chk("choque_no_movio", bus.CR_MOVIO, 0);
        bus.CR_CHOQUE = 1'b0;
        tick(1);
        chk("perdio_one_cycle", bus.CR_PERDIO, 0);
        tick(4);
        pulsar(B_UP);
        chk("muerta_frozen_posy", bus.CR_POSY, 0);
        bus.CR_CHOQUE = 1'b1;
        tick(1);
        chk("muerta_no_perdio", bus.CR_PERDIO, 0);
        bus.CR_CHOQUE = 1'b0;
        bus.CR_RANA_INI = 1'b1;
        tick(1);
        chk("respawn_posx", bus.CR_POSX, 3);
        chk("respawn_posy", bus.CR_POSY, 0);
        pulsar(B_UP);
        chk("respawn_hold_posy", bus.CR_POSY, 0);
        bus.CR_RANA_INI = 1'b0;
        tick(1);
        pulsar(B_UP);
        chk("rearmed_move_posy", bus.CR_POSY, 1);
        chk("rearmed_move_movio", bus.CR_MOVIO, 1);

        // Asynchronous reset mid-lockout
        #2;
        CR_RESET = 1'b1;
        #1;
        chk("async_reset_posy", bus.CR_POSY, 0);
        chk("async_reset_movio", bus.CR_MOVIO, 0);
        tick(1);
        CR_RESET = 1'b0;
        tick(1);
        pulsar(B_UP);
        chk("post_reset_move", bus.CR_POSY, 1);

        // Per-frog timeout
        rearm();
        tick(49);
        chk("timeout_pre", bus.CR_PERDIO, 0);
        tick(1);
        chk("timeout_pulse", bus.CR_PERDIO, 32'(TIMEOUT_EN));
        tick(1);
        chk("timeout_post", bus.CR_PERDIO, 0);
        pulsar(B_UP);
        chk("timeout_after_move", bus.CR_POSY, TIMEOUT_EN ? 32'd0 : 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
